// File: rtl/led_frame_receiver.sv
// Single-wire LED stripe receiver: decodes pulse-width bits into
// 24-bit frames and groups them into sets separated by long low gaps.
module led_frame_receiver #(
   parameter logic [15:0] L_TIME = 16'd80,
   parameter logic [15:0] S_TIME = 16'd40,
   parameter logic [15:0] R_TIME = 16'd5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_stripe_pin,
   output logic [23:0] frame_data,
   output logic [2:0]  frame_index,
   output logic        frame_valid,
   output logic        set_done,
   output logic [3:0]  frame_count,
   output logic        bit_error,
   output logic        partial_error,
   output logic        overflow,
   output logic        rx_busy
);

   localparam logic [16:0] H_MAX  = {L_TIME, 1'b0};
   localparam logic [16:0] LS_SUM = {1'b0, L_TIME} + {1'b0, S_TIME};
   localparam logic [15:0] H_THR  = LS_SUM[16:1];
   localparam logic [15:0] H_MIN  = {1'b0, S_TIME[15:1]};

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t state, state_n;

   logic s_meta, s, s_d;
   logic [15:0] scnt, scnt_n;
   logic [15:0] hcnt, hcnt_n;
   logic [15:0] lcnt, lcnt_n;
   logic [22:0] sr, sr_n;
   logic [4:0]  bit_cnt, bit_cnt_n;
   logic [3:0]  frm_cnt, frm_cnt_n;
   logic [23:0] frame_data_n;
   logic [2:0]  frame_index_n;
   logic [3:0]  frame_count_n;
   logic        overflow_n;
   logic        fv_n, sd_n, be_n, pe_n;

   logic [15:0] s_inc, h_inc, l_inc;
   logic        bit_v;
   logic [23:0] shifted;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign s_inc   = sat_inc(scnt);
   assign h_inc   = sat_inc(hcnt);
   assign l_inc   = sat_inc(lcnt);
   assign bit_v   = (hcnt >= H_THR);
   // The 24th bit goes straight to frame_data, so 23 stored bits suffice.
   assign shifted = {sr, bit_v};
   assign rx_busy = (state == HIGH) || (state == LOW);

   always_comb begin
      state_n       = state;
      scnt_n        = scnt;
      hcnt_n        = hcnt;
      lcnt_n        = lcnt;
      sr_n          = sr;
      bit_cnt_n     = bit_cnt;
      frm_cnt_n     = frm_cnt;
      frame_data_n  = frame_data;
      frame_index_n = frame_index;
      frame_count_n = frame_count;
      overflow_n    = overflow;
      fv_n          = 1'b0;
      sd_n          = 1'b0;
      be_n          = 1'b0;
      pe_n          = 1'b0;
      unique case (state)
         SYNC: begin
            if (s) begin
               scnt_n = 16'd0;
            end else if (s_inc >= R_TIME) begin
               scnt_n  = 16'd0;
               state_n = IDLE;
            end else begin
               scnt_n = s_inc;
            end
         end
         IDLE: begin
            if (s && !s_d) begin
               hcnt_n  = 16'd1;
               state_n = HIGH;
            end
         end
         HIGH: begin
            if (s) begin
               hcnt_n = h_inc;
               if ({1'b0, h_inc} >= H_MAX) begin
                  be_n      = 1'b1;
                  bit_cnt_n = 5'd0;
                  scnt_n    = 16'd0;
                  state_n   = SYNC;
               end
            end else if (hcnt < H_MIN) begin
               be_n      = 1'b1;
               bit_cnt_n = 5'd0;
               scnt_n    = 16'd0;
               state_n   = SYNC;
            end else begin
               sr_n    = shifted[22:0];
               lcnt_n  = 16'd1;
               state_n = LOW;
               if (bit_cnt == 5'd23) begin
                  bit_cnt_n = 5'd0;
                  if (frm_cnt < 4'd8) begin
                     frame_data_n  = shifted;
                     frame_index_n = frm_cnt[2:0];
                     fv_n          = 1'b1;
                     frm_cnt_n     = frm_cnt + 4'd1;
                  end else begin
                     overflow_n = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 5'd1;
               end
            end
         end
         LOW: begin
            if (s) begin
               hcnt_n  = 16'd1;
               state_n = HIGH;
            end else if (l_inc >= R_TIME) begin
               lcnt_n        = l_inc;
               pe_n          = (bit_cnt != 5'd0);
               bit_cnt_n     = 5'd0;
               sr_n          = 23'd0;
               sd_n          = 1'b1;
               frame_count_n = frm_cnt;
               frm_cnt_n     = 4'd0;
               overflow_n    = 1'b0;
               state_n       = IDLE;
            end else begin
               lcnt_n = l_inc;
            end
         end
         default: state_n = SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SYNC;
         s_meta        <= 1'b0;
         s             <= 1'b0;
         s_d           <= 1'b0;
         scnt          <= 16'd0;
         hcnt          <= 16'd0;
         lcnt          <= 16'd0;
         sr            <= 23'd0;
         bit_cnt       <= 5'd0;
         frm_cnt       <= 4'd0;
         frame_data    <= 24'd0;
         frame_index   <= 3'd0;
         frame_count   <= 4'd0;
         overflow      <= 1'b0;
         frame_valid   <= 1'b0;
         set_done      <= 1'b0;
         bit_error     <= 1'b0;
         partial_error <= 1'b0;
      end else begin
         state         <= state_n;
         s_meta        <= led_stripe_pin;
         s             <= s_meta;
         s_d           <= s;
         scnt          <= scnt_n;
         hcnt          <= hcnt_n;
         lcnt          <= lcnt_n;
         sr            <= sr_n;
         bit_cnt       <= bit_cnt_n;
         frm_cnt       <= frm_cnt_n;
         frame_data    <= frame_data_n;
         frame_index   <= frame_index_n;
         frame_count   <= frame_count_n;
         overflow      <= overflow_n;
         frame_valid   <= fv_n;
         set_done      <= sd_n;
         bit_error     <= be_n;
         partial_error <= pe_n;
      end
   end

endmodule

// File: tb/tb_led_frame_receiver.sv
// Directed bench for led_frame_receiver with a frame/set scoreboard.
// The reset gap is shortened to keep the run short.
module tb_led_frame_receiver;

   localparam int R = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pin;
   logic [23:0] frame_data;
   logic [2:0]  frame_index;
   logic        frame_valid;
   logic        set_done;
   logic [3:0]  frame_count;
   logic        bit_error;
   logic        partial_error;
   logic        overflow;
   logic        rx_busy;

   led_frame_receiver #(
      .L_TIME(16'd80),
      .S_TIME(16'd40),
      .R_TIME(16'(R))
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .led_stripe_pin(pin),
      .frame_data    (frame_data),
      .frame_index   (frame_index),
      .frame_valid   (frame_valid),
      .set_done      (set_done),
      .frame_count   (frame_count),
      .bit_error     (bit_error),
      .partial_error (partial_error),
      .overflow      (overflow),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   int nchk   = 0;
   int npass  = 0;
   int nfail  = 0;
   int sd_cnt = 0;
   int be_cnt = 0;
   int pe_cnt = 0;

   logic [26:0] exp_q[$];
   logic [3:0]  fc_q[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every cycle of the run passes through here, so outputs are
   // scored at each falling edge.
   task automatic tick();
      logic [26:0] e;
      logic [3:0]  f;
      @(negedge clk);
      if (frame_valid) begin
         chk("fv_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("frame_idx_data", 32'({frame_index, frame_data}), 32'(e));
         end
      end
      if (set_done) begin
         sd_cnt++;
         chk("sd_fv_overlap", 32'(frame_valid), 32'd0);
         chk("sd_expected", 32'(fc_q.size() != 0), 32'd1);
         if (fc_q.size() != 0) begin
            f = fc_q.pop_front();
            chk("frame_count", 32'(frame_count), 32'(f));
         end
      end
      if (bit_error) be_cnt++;
      if (partial_error) pe_cnt++;
   endtask

   task automatic hold(input logic v, input int n);
      pin = v;
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      if (b) begin
         hold(1'b1, 80);
         hold(1'b0, 40);
      end else begin
         hold(1'b1, 40);
         hold(1'b0, 80);
      end
   endtask

   task automatic send_bits(input logic [23:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
   endtask

   initial begin
      rst = 1'b1;
      pin = 1'b0;
      repeat (3) tick();
      chk("rst_data", 32'(frame_data), 32'd0);
      chk("rst_index", 32'(frame_index), 32'd0);
      chk("rst_count", 32'(frame_count), 32'd0);
      chk("rst_flags", 32'({frame_valid, set_done, bit_error,
                            partial_error, overflow, rx_busy}), 32'd0);
      rst = 1'b0;

      // Eight frames after the initial gap
      hold(1'b0, R + 10);
      for (int i = 0; i < 8; i++)
         exp_q.push_back({3'(i), 24'(i + 1)});
      fc_q.push_back(4'd8);
      for (int i = 1; i <= 8; i++) send_bits(24'(i), 24);
      hold(1'b0, R + 20);
      chk("set1_done", 32'(sd_cnt), 32'd1);
      chk("set1_left", 32'(exp_q.size()), 32'd0);
      chk("set1_no_err", 32'(be_cnt + pe_cnt), 32'd0);
      chk("hold_data", 32'(frame_data), 32'h000008);
      chk("hold_index", 32'(frame_index), 32'd7);
      chk("hold_count", 32'(frame_count), 32'd8);

      // High widths 159 -> 1, 59 -> 0, 60 -> 1, 20 -> 0
      exp_q.push_back({3'd0, 24'hAA5A5A});
      fc_q.push_back(4'd1);
      hold(1'b1, 159);
      hold(1'b0, 40);
      hold(1'b1, 59);
      hold(1'b0, 80);
      hold(1'b1, 60);
      hold(1'b0, 80);
      hold(1'b1, 20);
      hold(1'b0, 80);
      send_bits(24'h0A5A5A, 20);
      hold(1'b0, R + 20);
      chk("thr_done", 32'(sd_cnt), 32'd2);
      chk("thr_left", 32'(exp_q.size()), 32'd0);
      chk("thr_no_err", 32'(be_cnt), 32'd0);

      // High 160 is too long
      pin = 1'b1;
      repeat (100) tick();
      chk("busy_high", 32'(rx_busy), 32'd1);
      repeat (60) tick();
      pin = 1'b0;
      tick();
      chk("be_before_160", 32'(bit_error), 32'd0);
      tick();
      chk("be_at_160", 32'(bit_error), 32'd1);
      hold(1'b0, 98);
      hold(1'b1, 20);
      chk("sync_not_busy", 32'(rx_busy), 32'd0);
      hold(1'b1, 20);
      hold(1'b0, R + 20);
      chk("be_cnt_160", 32'(be_cnt), 32'd1);
      chk("no_sd_from_sync", 32'(sd_cnt), 32'd2);

      // Glitch, then a frame that must be ignored
      hold(1'b1, 10);
      hold(1'b0, 40);
      send_bits(24'h123456, 24);
      hold(1'b0, R + 20);
      chk("glitch_be", 32'(be_cnt), 32'd2);
      chk("glitch_no_sd", 32'(sd_cnt), 32'd2);
      chk("glitch_data_held", 32'(frame_data), 32'hAA5A5A);

      // Twelve bits then a gap
      fc_q.push_back(4'd0);
      send_bits(24'h000ABC, 12);
      hold(1'b0, R + 20);
      chk("part_pe", 32'(pe_cnt), 32'd1);
      chk("part_sd", 32'(sd_cnt), 32'd3);
      chk("part_count", 32'(frame_count), 32'd0);

      // Ten frames in one set
      for (int i = 0; i < 8; i++)
         exp_q.push_back({3'(i), 24'hC00000 | 24'(i)});
      fc_q.push_back(4'd8);
      for (int i = 0; i < 10; i++) begin
         send_bits(24'hC00000 | 24'(i), 24);
         if (i == 7) chk("ovf_after8", 32'(overflow), 32'd0);
         if (i == 8) chk("ovf_after9", 32'(overflow), 32'd1);
      end
      chk("ovf_after10", 32'(overflow), 32'd1);
      hold(1'b0, R + 20);
      chk("ovf_cleared", 32'(overflow), 32'd0);
      chk("ovf_count", 32'(frame_count), 32'd8);
      chk("ovf_sd", 32'(sd_cnt), 32'd4);
      chk("ovf_left", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a frame
      send_bits(24'h0002AB, 10);
      rst = 1'b1;
      pin = 1'b0;
      repeat (3) tick();
      chk("rst2_busy", 32'(rx_busy), 32'd0);
      chk("rst2_data", 32'(frame_data), 32'd0);
      chk("rst2_count", 32'(frame_count), 32'd0);
      rst = 1'b0;
      send_bits(24'h777777, 24);
      hold(1'b0, R + 20);
      chk("rst2_no_sd", 32'(sd_cnt), 32'd4);
      exp_q.push_back({3'd0, 24'h5A5A5A});
      fc_q.push_back(4'd1);
      send_bits(24'h5A5A5A, 24);
      hold(1'b0, R + 20);
      chk("rst2_sd", 32'(sd_cnt), 32'd5);
      chk("rst2_left", 32'(exp_q.size() + fc_q.size()), 32'd0);
      chk("final_be", 32'(be_cnt), 32'd2);
      chk("final_pe", 32'(pe_cnt), 32'd1);
      chk("final_data", 32'(frame_data), 32'h5A5A5A);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/led_frame_receiver.md
LED_FRAME_RECEIVER -- requirements
Module: led_frame_receiver

Interface
REQ-001 Parameter L_TIME, default 16'd80: long pulse phase width, in clk cycles.
REQ-002 Parameter S_TIME, default 16'd40: short pulse phase width, in clk cycles.
REQ-003 Parameter R_TIME, default 16'd5000: continuous-low width that marks a reset/latch gap, in clk cycles.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 led_stripe_pin  input  1  asynchronous single-wire LED stripe data line.
REQ-007 frame_data  output  24  last completed frame, MSB first on the wire.
REQ-008 frame_index  output  3  position of frame_data within the current set (0..7).
REQ-009 frame_valid  output  1  one-cycle pulse; frame_data and frame_index valid.
REQ-010 set_done  output  1  one-cycle pulse on detection of a reset gap that ends a set.
REQ-011 frame_count  output  4  frames accepted in the finished set (0..8); valid while set_done is high, held until the next set_done.
REQ-012 bit_error  output  1  one-cycle pulse on an illegal high-pulse width.
REQ-013 partial_error  output  1  one-cycle pulse when a reset gap arrives with 1..23 bits pending.
REQ-014 overflow  output  1  sticky flag: more than 8 frames in the current set; cleared on set_done or rst.
REQ-015 rx_busy  output  1  high in states HIGH and LOW.

Function
REQ-016 Synchronise led_stripe_pin with two flops to "s"; all decoding uses s. Pin-to-s latency is 2 cycles.
REQ-017 FSM states: SYNC, IDLE, HIGH, LOW. After reset the FSM is in SYNC.
REQ-018 SYNC: count consecutive s=0 cycles; any s=1 clears the count. On reaching R_TIME go to IDLE. No set_done is issued from SYNC.
REQ-019 IDLE: a rising edge of s goes to HIGH with hcnt=1.
REQ-020 HIGH: increment hcnt on each s=1 cycle.
REQ-021 HIGH: if hcnt reaches 2*L_TIME while s is still 1, pulse bit_error, clear the bit counter, and go to SYNC.
REQ-022 HIGH, on a falling edge of s: if hcnt < S_TIME/2, pulse bit_error, clear the bit counter, and go to SYNC.
REQ-023 Otherwise on that falling edge: bit = 1 if hcnt >= (L_TIME+S_TIME)/2, else 0. Shift the bit into a 24-bit register, increment the bit counter (0..23), and go to LOW with lcnt=1.
REQ-024 LOW: increment lcnt on each s=0 cycle.
REQ-025 LOW: a rising edge of s goes to HIGH with hcnt=1; low width below R_TIME is always legal.
REQ-026 LOW: when lcnt reaches R_TIME:
- if the bit counter is nonzero, pulse partial_error and discard the pending bits;
- pulse set_done and load frame_count;
- clear the frame counter and overflow;
- go to IDLE.
REQ-027 On the 24th bit, the bit counter wraps to 0. If fewer than 8 frames have been accepted in this set, the cycle after the falling edge:
- frame_data = the shift register;
- frame_index = accepted-frame count;
- frame_valid = 1;
- the frame counter increments.
REQ-028 A 9th or later frame in the same set: no frame_valid, overflow set, frame_count saturates at 8.
REQ-029 frame_data and frame_index hold their values between frame_valid pulses.
REQ-030 Counter widths: hcnt, lcnt, and the SYNC counter are 16 bits and saturate; they never wrap.
REQ-031 Error and set_done pulses last exactly one cycle each.
REQ-032 frame_valid and set_done never assert in the same cycle: the 24th-bit frame_valid always precedes the reset gap by at least R_TIME cycles.

Reset
REQ-033 While rst is high at a clk edge:
- FSM = SYNC;
- synchroniser, shift register, and all counters = 0;
- frame_data=0, frame_index=0, frame_valid=0, set_done=0, frame_count=0, bit_error=0, partial_error=0, overflow=0, rx_busy=0.
REQ-034 rst asserted mid-frame discards all pending bits. After release, the line must show R_TIME low cycles before any bit is decoded.

Verification
REQ-035 Low 5000 cycles, then 8 frames 0x000001..0x000008 ('1' = 80 high/40 low, '0' = 40 high/80 low), then low 5000 -> 8 frame_valid pulses with index 0..7 and matching data; set_done with frame_count=8; no errors.
REQ-036 Threshold check: high 59 decodes as 0; high 60 decodes as 1; high 159 is accepted; high 160 -> bit_error at hcnt=160 and FSM=SYNC.
REQ-037 Glitch: high 10 cycles after a valid gap -> bit_error, no frame_valid; the next frame decodes only after a 5000-cycle low.
REQ-038 12 bits then low 5000 -> partial_error and set_done with frame_count=0; no frame_valid.
REQ-039 10 frames then gap -> 8 frame_valid pulses, overflow=1 until set_done, frame_count=8, then overflow=0.
REQ-040 rst pulsed after bit 10 of a frame, then frames sent without a gap -> no output until 5000 low cycles; the next set decodes normally.
